add_sub_pipe: RTL

//   Parametrised, pipelined integer adder/subtractor with carry-in, carry-out and ALU flags.

---
 rtl/add_sub_pipe_pkg.sv | 29 ++
 rtl/add_sub_pipe_add_seg.sv | 28 ++
 rtl/add_sub_pipe.sv | 136 +++++++++++++
 3 files changed

// File: rtl/add_sub_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding,
// ALU flag bus layout and small op decode helpers.
package add_sub_pipe_pkg;

  // Encoded as {op_use_cin, op_sub}
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic lt;
    logic ltu;
  } alu_flags_t;

  function automatic logic op_is_sub(op_e op);
    return op[0];
  endfunction

  function automatic logic op_carry_in(op_e op, logic cin);
    return op[1] ? cin : op[0];
  endfunction

endpackage

// File: rtl/add_sub_pipe_add_seg.sv
// W-bit ripple-carry segment: one full-adder chain with carry in and out.
module add_seg
  import add_sub_pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[W];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal ripple
// segments, each followed by a register stage, with a valid/ready handshake.
module add_sub_pipe
  import add_sub_pipe_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] op_a,
  input  logic [DATA_LEN-1:0] op_b,
  input  logic                op_sub,
  input  logic                op_use_cin,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                zero,
  output logic                lt,
  output logic                ltu
);

  localparam int unsigned W   = DATA_LEN / STAGES;
  localparam int unsigned MSB = DATA_LEN - 1;

  if (STAGES == 0 || (DATA_LEN % STAGES) != 0) begin : g_param_err
    $error("add_sub_pipe: DATA_LEN must be a multiple of STAGES");
  end

  op_e                 op;
  logic                en;
  logic                accept;
  logic                c0;
  logic [DATA_LEN-1:0] b_eff;

  // Operands travel whole; each stage only consumes its own slice.
  logic [DATA_LEN-1:0] a_q [STAGES];
  logic [DATA_LEN-1:0] b_q [STAGES];
  logic [DATA_LEN-1:0] s_q [STAGES];
  logic                c_q [STAGES];
  logic                v_q [STAGES];
  alu_flags_t          flags_q;

  assign op        = op_e'({op_use_cin, op_sub});
  assign b_eff     = op_b ^ {DATA_LEN{op_is_sub(op)}};
  assign c0        = op_carry_in(op, cin);
  assign out_valid = v_q[STAGES-1];
  assign en        = ~(out_valid & ~out_ready);
  assign in_ready  = ~flush & en;
  assign accept    = in_valid & in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [DATA_LEN-1:0] a_in, b_in, s_in, s_nxt;
    logic                c_in, v_in, c_nxt;
    logic [W-1:0]        seg_s;

    if (k == 0) begin : g_first
      assign a_in = op_a;
      assign b_in = b_eff;
      assign s_in = '0;
      assign c_in = c0;
      assign v_in = accept;
    end else begin : g_next
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign s_in = s_q[k-1];
      assign c_in = c_q[k-1];
      assign v_in = v_q[k-1];
    end

    add_seg #(.W(W)) u_seg (
      .a    (a_in[k*W +: W]),
      .b    (b_in[k*W +: W]),
      .cin  (c_in),
      .s    (seg_s),
      .cout (c_nxt)
    );

    always_comb begin
      s_nxt            = s_in;
      s_nxt[k*W +: W]  = seg_s;
    end

    // Flush only kills valid bits; a stall freezes data and valid alike.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end else begin
        if (flush)   v_q[k] <= 1'b0;
        else if (en) v_q[k] <= v_in;
        if (en) begin
          a_q[k] <= a_in;
          b_q[k] <= b_in;
          s_q[k] <= s_nxt;
          c_q[k] <= c_nxt;
        end
      end
    end

    if (k == STAGES - 1) begin : g_flags
      alu_flags_t flags_nxt;

      always_comb begin
        flags_nxt      = '0;
        flags_nxt.cout = c_nxt;
        flags_nxt.ovf  = (a_in[MSB] == b_in[MSB]) & (s_nxt[MSB] != a_in[MSB]);
        flags_nxt.zero = ~|s_nxt;
        flags_nxt.lt   = s_nxt[MSB] ^ flags_nxt.ovf;
        flags_nxt.ltu  = ~c_nxt;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)     flags_q <= '0;
        else if (en) flags_q <= flags_nxt;
      end
    end
  end

  assign sum  = s_q[STAGES-1];
  assign cout = flags_q.cout;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;
  assign lt   = flags_q.lt;
  assign ltu  = flags_q.ltu;

endmodule
